hazard_sequencer: RTL and testbench
===================================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
- REQ-001 SHALL provide parameter: CNT_W, 32, width of each performance counter.
- REQ-002 SHALL have port: clk  input  1  pipeline clock; all state updates on its rising edge.
- REQ-003 SHALL have port: rst  input  1  asynchronous reset, active-high.
- REQ-004 SHALL have inputs: id_valid 1, id_rs1 5, id_rs2 5, id_uses_rs1 1, id_uses_rs2 1, the decoded instruction in ID.
- REQ-005 SHALL have inputs: ex_valid 1, ex_is_load 1, ex_rd 5, the instruction in EX.
- REQ-006 SHALL have inputs: mispredict 1, which is the inverse of the correct-PC-prediction signal consumed by ID.
- REQ-007 SHALL have inputs: imem_read 1, imem_resp 1, dmem_read 1, dmem_write 1, dmem_resp 1.
- REQ-008 SHALL have outputs: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, each 1 bit, which are stage-register enables.
- REQ-009 SHALL have outputs: bubble_id_ex 1 (write invalid packet into ID/EX), flush_if_id 1 (write invalid packet into IF/ID), and state 2 (debug).

Function
- REQ-010 SHALL compute mem_busy = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp).
- REQ-011 SHALL compute lu_hazard = ex_valid & ex_is_load & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- REQ-012 SHALL define kill = mispredict | flush_pending, where flush_pending is an internal register.
- REQ-013 SHALL, when mem_busy is asserted (freeze), drive all load_* = 0, bubble_id_ex = 0, and flush_if_id = 0.
- REQ-014 SHALL, in the absence of freeze and when kill is asserted, drive all load_* = 1, flush_if_id = 1, and bubble_id_ex = 1; no load-use stall is raised, because the ID instruction is killed.
- REQ-015 SHALL, in the absence of freeze and kill, when lu_hazard is asserted, drive load_pc = 0, load_if_id = 0, load_id_ex = 1, bubble_id_ex = 1, load_ex_mem = 1, and load_mem_wb = 1.
- REQ-016 SHALL otherwise drive all load_* = 1, bubble_id_ex = 0, and flush_if_id = 0.
- REQ-017 SHALL apply output priority in the order freeze > kill > lu_hazard > run.
- REQ-018 SHALL set flush_pending on any edge where mispredict = 1 and freeze is active, and clear it on the first non-freeze edge.
- REQ-019 SHALL implement FSM states RUN = 0, LU_STALL = 1, MEM_WAIT = 2.
- REQ-020 SHALL transition to MEM_WAIT from any state when freeze is active.
- REQ-021 SHALL transition to LU_STALL from any state when the REQ-015 case applies.
- REQ-022 SHALL transition to RUN in all other cases.
- REQ-023 SHALL guarantee a load-use stall lasts exactly 1 cycle absent freeze, since the bubble removes the load dependency; LU_STALL followed by lu_hazard = 1 SHALL be flagged by an assertion.
- REQ-024 SHALL, when freeze occurs during LU_STALL, hold the stall; the hazard is re-evaluated on release.
- REQ-025 SHALL drive outputs combinationally from the inputs and the registered state, with zero-cycle latency.

Reset
- REQ-026 SHALL, while rst = 1, drive all load_* = 0, bubble_id_ex = 0, flush_if_id = 0, state = RUN, flush_pending = 0, and all counters = 0.
- REQ-027 SHALL, when rst is asserted mid-stall or mid-freeze, discard the stall and any pending flush immediately, without waiting for a clock edge.

Configuration
- REQ-028 SHALL include, under HAZARD_SEQ_PERF_CNT_EN, output ports perf_freeze_cycles, perf_lu_stalls, and perf_flushes, each CNT_W wide.
- REQ-029 SHALL, with HAZARD_SEQ_PERF_CNT_EN defined, increment each counter by 1 per freeze cycle, per REQ-015 cycle, and per REQ-014 cycle respectively, with modulo 2^CNT_W wrap-around.
- REQ-030 SHALL, without HAZARD_SEQ_PERF_CNT_EN, omit the counters and their ports and leave all other behaviour unchanged.

Verification
- REQ-031 SHALL cover: ex_is_load = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 -> one cycle with load_pc = 0, load_if_id = 0, bubble_id_ex = 1, state = 1, then state = 0.
- REQ-032 SHALL cover: same as REQ-031 with ex_rd = 0 -> no stall, all load_* = 1.
- REQ-033 SHALL cover: dmem_read = 1 with dmem_resp = 0 for 4 cycles, mispredict pulsed in cycle 2 -> all load_* = 0 for 4 cycles, flush_pending = 1, then on release flush_if_id = 1 and bubble_id_ex = 1 for exactly 1 cycle.
- REQ-034 SHALL cover: mispredict and lu_hazard in the same cycle -> flush_if_id = 1, load_pc = 1, state = RUN.
- REQ-035 SHALL cover: rst asserted during MEM_WAIT -> state = 0 and flush_pending = 0 asynchronously, before the next clk edge.
- REQ-036 SHALL cover, with HAZARD_SEQ_PERF_CNT_EN: perf_lu_stalls preloaded to 2^CNT_W-1 plus one REQ-015 cycle -> perf_lu_stalls = 0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//
// Pipeline hazard sequencer for a classic five-stage in-order core.
// It combines three sources of pipeline control into one set of stage-register
// enables plus bubble/flush strobes:
//   * memory freeze : an outstanding instruction or data memory access
//                     that has not yet been answered stops every stage
//   * kill          : a branch mispredict (live, or remembered from a freeze)
//                     squashes the IF/ID and ID/EX contents
//   * load-use      : the ID instruction reads the destination of a load
//                     that is currently in EX; PC and IF/ID hold for one
//                     cycle while a bubble is written into ID/EX
// Priority is freeze > kill > load-use > run.
// All outputs are combinational from the inputs and the registered state.
//
// Optional feature macro: HAZARD_SEQ_PERF_CNT_EN
//   When defined, three CNT_W-bit wrap-around performance counters are
//   added (freeze cycles, load-use stall cycles, flush cycles) together
//   with their output ports.  When undefined, neither exists.
//
// Parameters
//   CNT_W           width of each performance counter
//
// Ports
//   clk             pipeline clock, rising edge
//   rst             asynchronous reset, active high
//   id_valid        ID stage holds a valid instruction
//   id_rs1/id_rs2   source register numbers of the ID instruction
//   id_uses_rs1/2   the ID instruction actually reads rs1/rs2
//   ex_valid        EX stage holds a valid instruction
//   ex_is_load      the EX instruction is a load
//   ex_rd           destination register of the EX instruction
//   mispredict      branch resolved against the prediction
//   imem_read       instruction fetch request outstanding
//   imem_resp       instruction memory answers this cycle
//   dmem_read/write data memory request outstanding
//   dmem_resp       data memory answers this cycle
//   load_pc .. load_mem_wb  stage-register enables
//   bubble_id_ex    write an invalid packet into ID/EX
//   flush_if_id     write an invalid packet into IF/ID
//   state           current sequencer state (debug)
//   perf_*          performance counters (feature macro only)
// -----------------------------------------------------------------------------
module hazard_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             mispredict,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic [1:0]       state
`ifdef HAZARD_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_freeze_cycles,
  output logic [CNT_W-1:0] perf_lu_stalls,
  output logic [CNT_W-1:0] perf_flushes
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   flush_pending_reg;
  logic   flush_pending_next;

  logic   mem_busy;
  logic   rs1_match;
  logic   rs2_match;
  logic   lu_hazard;
  logic   kill;

  // Mutually exclusive cycle classifications, all forced low while in reset
  // so that neither the outputs nor the counters react during reset.
  logic   freeze_cycle;
  logic   kill_cycle;
  logic   stall_cycle;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign mem_busy  = (imem_read & ~imem_resp)
                   | ((dmem_read | dmem_write) & ~dmem_resp);

  assign rs1_match = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_match = id_uses_rs2 & (id_rs2 == ex_rd);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu_hazard = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid
                   & (rs1_match | rs2_match);

  // A mispredict seen while frozen is remembered and replayed on release.
  assign kill = mispredict | flush_pending_reg;

  assign freeze_cycle = ~rst & mem_busy;
  assign kill_cycle   = ~rst & ~mem_busy & kill;
  assign stall_cycle  = ~rst & ~mem_busy & ~kill & lu_hazard;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= RUN;
      flush_pending_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      flush_pending_reg <= flush_pending_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next         = RUN;
    flush_pending_next = 1'b0;
    load_pc            = 1'b0;
    load_if_id         = 1'b0;
    load_id_ex         = 1'b0;
    load_ex_mem        = 1'b0;
    load_mem_wb        = 1'b0;
    bubble_id_ex       = 1'b0;
    flush_if_id        = 1'b0;

    // Next state: the current state never gates the decision, so a stall
    // interrupted by a freeze is simply re-evaluated from the live inputs
    // once memory answers.
    if (mem_busy) begin
      state_next         = MEM_WAIT;
      flush_pending_next = flush_pending_reg | mispredict;
    end else if (!kill && lu_hazard) begin
      state_next = LU_STALL;
    end

    // Outputs: reset and freeze both leave every strobe at its default of 0.
    if (rst || freeze_cycle) begin
      load_pc = 1'b0;
    end else if (kill_cycle) begin
      // The killed ID instruction cannot cause a load-use stall.
      load_pc      = 1'b1;
      load_if_id   = 1'b1;
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
      bubble_id_ex = 1'b1;
      flush_if_id  = 1'b1;
    end else if (stall_cycle) begin
      // Hold PC and IF/ID, insert a bubble behind the load.
      load_id_ex   = 1'b1;
      bubble_id_ex = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
    end else begin
      load_pc      = 1'b1;
      load_if_id   = 1'b1;
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
    end
  end

  assign state = state_reg;

  // The bubble written during a stall moves the load out of EX, so a second
  // consecutive unfrozen, unkilled load-use hazard points at a broken pipeline.
  a_lu_stall_single_cycle : assert property (
    @(posedge clk) disable iff (rst)
      (state_reg == LU_STALL && !mem_busy && !kill) |-> !lu_hazard
  );

  // A counter narrower than one bit is meaningless; this block only exists
  // for an illegal CNT_W and makes such a configuration easy to spot.
  if (CNT_W < 1) begin : g_cnt_w_invalid
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_SEQ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0] cnt_event;

  // Index 0: freeze cycles, 1: load-use stall cycles, 2: flush cycles.
  assign cnt_event = {kill_cycle, stall_cycle, freeze_cycle};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    // Plain binary add wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (cnt_event[gi]) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  assign perf_freeze_cycles = g_cnt[0].cnt_reg;
  assign perf_lu_stalls     = g_cnt[1].cnt_reg;
  assign perf_flushes       = g_cnt[2].cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
//
// Self-checking bench for hazard_sequencer.  A table of single-cycle vectors
// (inputs + expected outputs/state) is applied in order; expected records go
// into a scoreboard queue when a vector is driven and are popped and compared
// at the following falling edge.  Hand-written sequences cover the frozen
// mispredict replay, asynchronous reset during a freeze, and (when the
// counter feature macro is defined) counter wrap-around.
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;

  localparam int TB_CNT_W = 3;

  localparam logic [4:0] LD_ALL   = 5'b11111;
  localparam logic [4:0] LD_STALL = 5'b00111;
  localparam logic [4:0] LD_NONE  = 5'b00000;

  // {imem_read, imem_resp, dmem_read, dmem_write, dmem_resp}
  localparam logic [4:0] M_IDLE   = 5'b00000;
  localparam logic [4:0] M_IBUSY  = 5'b10000;
  localparam logic [4:0] M_IDONE  = 5'b11000;
  localparam logic [4:0] M_WBUSY  = 5'b00010;
  localparam logic [4:0] M_WDONE  = 5'b00011;
  localparam logic [4:0] M_RBUSY  = 5'b00100;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_valid;
  logic       ex_is_load;
  logic [4:0] ex_rd;
  logic       mispredict;
  logic       imem_read;
  logic       imem_resp;
  logic       dmem_read;
  logic       dmem_write;
  logic       dmem_resp;
  logic       load_pc;
  logic       load_if_id;
  logic       load_id_ex;
  logic       load_ex_mem;
  logic       load_mem_wb;
  logic       bubble_id_ex;
  logic       flush_if_id;
  logic [1:0] state;
`ifdef HAZARD_SEQ_PERF_CNT_EN
  logic [TB_CNT_W-1:0] perf_freeze_cycles;
  logic [TB_CNT_W-1:0] perf_lu_stalls;
  logic [TB_CNT_W-1:0] perf_flushes;
`endif

  hazard_sequencer #(.CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_valid     (ex_valid),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .mispredict   (mispredict),
    .imem_read    (imem_read),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_resp    (dmem_resp),
    .load_pc      (load_pc),
    .load_if_id   (load_if_id),
    .load_id_ex   (load_id_ex),
    .load_ex_mem  (load_ex_mem),
    .load_mem_wb  (load_mem_wb),
    .bubble_id_ex (bubble_id_ex),
    .flush_if_id  (flush_if_id),
    .state        (state)
`ifdef HAZARD_SEQ_PERF_CNT_EN
    ,
    .perf_freeze_cycles (perf_freeze_cycles),
    .perf_lu_stalls     (perf_lu_stalls),
    .perf_flushes       (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_valid;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic       mispredict;
    logic [4:0] mem;
    logic [8:0] exp;   // {load_pc..load_mem_wb, bubble_id_ex, flush_if_id, state}
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  m_freeze = 0;
  int  m_lu     = 0;
  int  m_flush  = 0;

  logic [8:0] outs;
  assign outs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                 bubble_id_ex, flush_if_id, state};

  function automatic logic [8:0] e(logic [4:0] ld, logic b, logic f, logic [1:0] st);
    return {ld, b, f, st};
  endfunction

  function automatic vec_t mk(string name, logic idv, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic exv, logic exl, logic [4:0] rd,
                              logic mp, logic [4:0] mem, logic [8:0] exp);
    vec_t v;
    v.name = name;       v.id_valid = idv;  v.id_rs1 = rs1;      v.id_rs2 = rs2;
    v.id_uses_rs1 = u1;  v.id_uses_rs2 = u2; v.ex_valid = exv;   v.ex_is_load = exl;
    v.ex_rd = rd;        v.mispredict = mp; v.mem = mem;         v.exp = exp;
    return v;
  endfunction

  // Load in EX writing x5, ID reads x5 through rs1.
  function automatic vec_t hz(string name, logic mp, logic [4:0] mem, logic [8:0] exp);
    return mk(name, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, mp, mem, exp);
  endfunction

  // No instructions of interest in ID or EX.
  function automatic vec_t idle(string name, logic mp, logic [4:0] mem, logic [8:0] exp);
    return mk(name, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, mp, mem, exp);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic drive(input vec_t v);
    id_valid    = v.id_valid;
    id_rs1      = v.id_rs1;
    id_rs2      = v.id_rs2;
    id_uses_rs1 = v.id_uses_rs1;
    id_uses_rs2 = v.id_uses_rs2;
    ex_valid    = v.ex_valid;
    ex_is_load  = v.ex_is_load;
    ex_rd       = v.ex_rd;
    mispredict  = v.mispredict;
    {imem_read, imem_resp, dmem_read, dmem_write, dmem_resp} = v.mem;
  endtask

  // One clock cycle: drive after the rising edge, compare at the falling edge.
  task automatic apply(input vec_t v);
    sb_t s;
    @(posedge clk);
    #1;
    drive(v);
    s.name = v.name;
    s.exp  = v.exp;
    sb.push_back(s);
    @(negedge clk);
    s = sb.pop_front();
    check(s.name, 32'(outs), 32'(s.exp));
    if (s.exp[8:4] == LD_NONE)  m_freeze++;
    if (s.exp[8:4] == LD_STALL) m_lu++;
    if (s.exp[2])               m_flush++;
    $display("txn %-20s outs=%09b exp=%09b", s.name, outs, s.exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];

    tbl.push_back(idle("idle",            1'b0, M_IDLE,  e(LD_ALL,   1'b0, 1'b0, 2'd0)));
    tbl.push_back(hz  ("lu_rs1",          1'b0, M_IDLE,  e(LD_STALL, 1'b1, 1'b0, 2'd0)));
    tbl.push_back(mk  ("after_stall", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, M_IDLE,
                       e(LD_ALL, 1'b0, 1'b0, 2'd1)));
    tbl.push_back(mk  ("rd_zero_rs5", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, M_IDLE,
                       e(LD_ALL, 1'b0, 1'b0, 2'd0)));
    tbl.push_back(mk  ("rd_zero_rs0", 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, M_IDLE,
                       e(LD_ALL, 1'b0, 1'b0, 2'd0)));
    tbl.push_back(mk  ("lu_rs2",      1'b1, 5'd7, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, M_IDLE,
                       e(LD_STALL, 1'b1, 1'b0, 2'd0)));
    tbl.push_back(idle("idle2",           1'b0, M_IDLE,  e(LD_ALL,   1'b0, 1'b0, 2'd1)));
    tbl.push_back(mk  ("rs2_unused",  1'b1, 5'd7, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, M_IDLE,
                       e(LD_ALL, 1'b0, 1'b0, 2'd0)));
    tbl.push_back(mk  ("not_load",    1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, M_IDLE,
                       e(LD_ALL, 1'b0, 1'b0, 2'd0)));
    tbl.push_back(mk  ("id_invalid",  1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, M_IDLE,
                       e(LD_ALL, 1'b0, 1'b0, 2'd0)));
    tbl.push_back(mk  ("ex_invalid",  1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, M_IDLE,
                       e(LD_ALL, 1'b0, 1'b0, 2'd0)));
    tbl.push_back(idle("mispredict",      1'b1, M_IDLE,  e(LD_ALL,   1'b1, 1'b1, 2'd0)));
    tbl.push_back(hz  ("kill_beats_lu",   1'b1, M_IDLE,  e(LD_ALL,   1'b1, 1'b1, 2'd0)));
    tbl.push_back(idle("imem_busy",       1'b0, M_IBUSY, e(LD_NONE,  1'b0, 1'b0, 2'd0)));
    tbl.push_back(idle("imem_done",       1'b0, M_IDONE, e(LD_ALL,   1'b0, 1'b0, 2'd2)));
    tbl.push_back(hz  ("freeze_beats_lu", 1'b0, M_WBUSY, e(LD_NONE,  1'b0, 1'b0, 2'd0)));
    tbl.push_back(hz  ("release_lu",      1'b0, M_WDONE, e(LD_STALL, 1'b1, 1'b0, 2'd2)));
    tbl.push_back(idle("idle3",           1'b0, M_IDLE,  e(LD_ALL,   1'b0, 1'b0, 2'd1)));
    tbl.push_back(hz  ("lu_again",        1'b0, M_IDLE,  e(LD_STALL, 1'b1, 1'b0, 2'd0)));
    tbl.push_back(hz  ("freeze_in_stall", 1'b0, M_RBUSY, e(LD_NONE,  1'b0, 1'b0, 2'd1)));
    tbl.push_back(hz  ("release_restall", 1'b0, M_IDLE,  e(LD_STALL, 1'b1, 1'b0, 2'd2)));
    tbl.push_back(idle("idle4",           1'b0, M_IDLE,  e(LD_ALL,   1'b0, 1'b0, 2'd1)));
    tbl.push_back(idle("freeze_beats_kill", 1'b1, M_IBUSY, e(LD_NONE, 1'b0, 1'b0, 2'd0)));
    tbl.push_back(idle("pending_replay",  1'b0, M_IDLE,  e(LD_ALL,   1'b1, 1'b1, 2'd2)));
    tbl.push_back(idle("idle5",           1'b0, M_IDLE,  e(LD_ALL,   1'b0, 1'b0, 2'd0)));

    // Reset: even with hazards and a mispredict on the inputs, nothing loads.
    rst = 1'b1;
    drive(idle("rst_idle", 1'b0, M_IDLE, 9'd0));
    @(negedge clk);
    drive(hz("rst_busy", 1'b1, M_IDLE, 9'd0));
    #1;
    check("reset_outs", 32'(outs), 32'(e(LD_NONE, 1'b0, 1'b0, 2'd0)));
    check("reset_pending", 32'(dut.flush_pending_reg), 32'd0);
    drive(idle("rst_idle", 1'b0, M_IDLE, 9'd0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Data read frozen four cycles, mispredict in the second; the flush is
    // replayed for exactly one cycle once memory answers.
    apply(idle("r33_frz1", 1'b0, M_RBUSY, e(LD_NONE, 1'b0, 1'b0, 2'd0)));
    apply(idle("r33_frz2", 1'b1, M_RBUSY, e(LD_NONE, 1'b0, 1'b0, 2'd2)));
    apply(idle("r33_frz3", 1'b0, M_RBUSY, e(LD_NONE, 1'b0, 1'b0, 2'd2)));
    check("r33_pending3", 32'(dut.flush_pending_reg), 32'd1);
    apply(idle("r33_frz4", 1'b0, M_RBUSY, e(LD_NONE, 1'b0, 1'b0, 2'd2)));
    check("r33_pending4", 32'(dut.flush_pending_reg), 32'd1);
    apply(idle("r33_release", 1'b0, M_IDLE, e(LD_ALL, 1'b1, 1'b1, 2'd2)));
    apply(idle("r33_after",   1'b0, M_IDLE, e(LD_ALL, 1'b0, 1'b0, 2'd0)));
    check("r33_pending_clr", 32'(dut.flush_pending_reg), 32'd0);

    // Asynchronous reset in the middle of a freeze with a flush pending.
    apply(idle("r35_frz_mp", 1'b1, M_IBUSY, e(LD_NONE, 1'b0, 1'b0, 2'd0)));
    apply(idle("r35_frz",    1'b0, M_IBUSY, e(LD_NONE, 1'b0, 1'b0, 2'd2)));
    check("r35_pending_set", 32'(dut.flush_pending_reg), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("r35_state_async",   32'(state), 32'd0);
    check("r35_pending_async", 32'(dut.flush_pending_reg), 32'd0);
    check("r35_outs_in_rst",   32'(outs), 32'(e(LD_NONE, 1'b0, 1'b0, 2'd0)));
    m_freeze = 0;
    m_lu     = 0;
    m_flush  = 0;
`ifdef HAZARD_SEQ_PERF_CNT_EN
    check("r35_cnt_clr", 32'(perf_freeze_cycles), 32'd0);
`endif
    drive(idle("r35_idle", 1'b0, M_IDLE, 9'd0));
    #1;
    rst = 1'b0;
    apply(idle("r35_after", 1'b0, M_IDLE, e(LD_ALL, 1'b0, 1'b0, 2'd0)));

`ifdef HAZARD_SEQ_PERF_CNT_EN
    apply(idle("cnt_frz",  1'b0, M_IBUSY, e(LD_NONE, 1'b0, 1'b0, 2'd0)));
    apply(idle("cnt_kill", 1'b1, M_IDLE,  e(LD_ALL,  1'b1, 1'b1, 2'd2)));
    apply(idle("cnt_idle", 1'b0, M_IDLE,  e(LD_ALL,  1'b0, 1'b0, 2'd0)));
    check("perf_freeze", 32'(perf_freeze_cycles), 32'(m_freeze % (1 << TB_CNT_W)));
    check("perf_flushes", 32'(perf_flushes),      32'(m_flush  % (1 << TB_CNT_W)));
    // Bring the stall counter to its all-ones value, then one more stall wraps it.
    for (int k = 0; k < (1 << TB_CNT_W) && (m_lu % (1 << TB_CNT_W)) != (1 << TB_CNT_W) - 1; k++) begin
      apply(hz  ("cnt_lu",      1'b0, M_IDLE, e(LD_STALL, 1'b1, 1'b0, 2'd0)));
      apply(idle("cnt_lu_idle", 1'b0, M_IDLE, e(LD_ALL,   1'b0, 1'b0, 2'd1)));
    end
    check("r36_lu_max", 32'(perf_lu_stalls), 32'((1 << TB_CNT_W) - 1));
    apply(hz  ("cnt_lu_wrap", 1'b0, M_IDLE, e(LD_STALL, 1'b1, 1'b0, 2'd0)));
    apply(idle("cnt_lu_idle", 1'b0, M_IDLE, e(LD_ALL,   1'b0, 1'b0, 2'd1)));
    check("r36_lu_wrap", 32'(perf_lu_stalls), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
